// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin arbiter sharing one external logical barrel shifter
// Rotates are built from two shifter passes, with a single-entry registered response port.
module shift_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  localparam int SW   = $clog2(WIDTH),
  localparam int IW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ*SW-1:0]    req_amt,
  input  logic [NREQ-1:0]       req_dir,
  input  logic [NREQ-1:0]       req_rot,
  output logic [WIDTH-1:0]      sh_data_in,
  output logic [SW-1:0]         sh_shift_amt,
  output logic                  sh_dir,
  input  logic [WIDTH-1:0]      sh_data_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IW-1:0]         rsp_id,
  output logic                  busy
);

  typedef enum logic {IDLE = 1'b0, SECOND = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    rr_ptr, grant_idx, lat_id;
  logic             grant_found, slot_free, arb_en, accept, go_second, load_rsp;
  logic [WIDTH-1:0] g_data, partial, lat_data;
  logic [SW-1:0]    g_amt, lat_amt;
  logic             g_dir, g_rot, lat_dir;

  // Walk downward so the smallest offset from rr_ptr+1 is the final winner.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = IW'(idx);
      end
    end
  end

  assign g_data    = req_data[int'(grant_idx)*WIDTH +: WIDTH];
  assign g_amt     = req_amt[int'(grant_idx)*SW +: SW];
  assign g_dir     = req_dir[grant_idx];
  assign g_rot     = req_rot[grant_idx];

  assign slot_free = !rsp_valid || rsp_ready;
  assign arb_en    = rst_n && (state == IDLE) && slot_free;
  assign accept    = arb_en && grant_found;
  assign go_second = accept && g_rot && (g_amt != '0);
  assign load_rsp  = (accept && !go_second) || (state == SECOND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go_second) state_nxt = SECOND;
      SECOND:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready    = '0;
    sh_data_in   = '0;
    sh_shift_amt = '0;
    sh_dir       = 1'b0;
    busy         = (state == SECOND);
    if (state == SECOND) begin
      sh_data_in   = lat_data;
      sh_shift_amt = SW'(WIDTH - int'(lat_amt));
      sh_dir       = !lat_dir;
    end else if (accept) begin
      req_ready[grant_idx] = 1'b1;
      sh_data_in           = g_data;
      sh_shift_amt         = g_amt;
      sh_dir               = g_dir;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= IW'(NREQ - 1);
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      partial   <= '0;
      lat_data  <= '0;
      lat_amt   <= '0;
      lat_dir   <= 1'b0;
      lat_id    <= '0;
    end else begin
      if (accept) rr_ptr <= grant_idx;
      if (go_second) begin
        partial  <= sh_data_out;
        lat_data <= g_data;
        lat_amt  <= g_amt;
        lat_dir  <= g_dir;
        lat_id   <= grant_idx;
      end
      if (load_rsp) begin
        rsp_valid <= 1'b1;
        rsp_data  <= (state == SECOND) ? (partial | sh_data_out) : sh_data_out;
        rsp_id    <= (state == SECOND) ? lat_id : grant_idx;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - self-checking bench for shift_arbiter with a behavioural model
module tb_shift_arbiter;
  localparam int W = 8;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req_valid, req_ready, req_dir, req_rot;
  logic [N*W-1:0] req_data;
  logic [N*3-1:0] req_amt;
  logic [W-1:0] sh_data_in, sh_data_out, rsp_data;
  logic [2:0]   sh_shift_amt;
  logic         sh_dir, rsp_valid, rsp_ready, busy;
  logic [1:0]   rsp_id;

  int errors = 0;
  int checks = 0;

  shift_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_amt(req_amt), .req_dir(req_dir), .req_rot(req_rot),
    .sh_data_in(sh_data_in), .sh_shift_amt(sh_shift_amt), .sh_dir(sh_dir),
    .sh_data_out(sh_data_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .busy(busy)
  );

  // External logical barrel shifter
  assign sh_data_out = sh_dir ? (sh_data_in >> sh_shift_amt) : (sh_data_in << sh_shift_amt);

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rotate(input logic [W-1:0] d, input int n, input bit right);
    logic [W-1:0] r;
    if (n == 0) r = d;
    else if (right) r = (d >> n) | (d << (W - n));
    else r = (d << n) | (d >> (W - n));
    return r;
  endfunction

  function automatic int pick(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  // Model: pending second pass holds the final rotate result computed directly.
  int           m_rr, m_pid, m_pamt, m_id;
  bit           m_busy, m_pdir, m_valid;
  logic [W-1:0] m_pdata, m_pres, m_data;

  always @(posedge clk or negedge rst_n) begin : model
    int g, n;
    logic [W-1:0] d;
    if (!rst_n) begin
      m_rr <= N - 1; m_busy <= 0; m_valid <= 0; m_data <= '0; m_id <= 0;
      m_pid <= 0; m_pamt <= 0; m_pdir <= 0; m_pdata <= '0; m_pres <= '0;
    end else if (m_busy) begin
      m_busy <= 0; m_valid <= 1; m_data <= m_pres; m_id <= m_pid;
    end else begin
      g = pick(m_rr, req_valid);
      if ((!m_valid || rsp_ready) && g >= 0) begin
        d = req_data[g*W +: W];
        n = int'(req_amt[g*3 +: 3]);
        m_rr <= g;
        if (req_rot[g] && n != 0) begin
          m_busy <= 1; m_valid <= 0;
          m_pid <= g; m_pamt <= n; m_pdir <= req_dir[g]; m_pdata <= d;
          m_pres <= rotate(d, n, req_dir[g]);
        end else begin
          m_valid <= 1; m_id <= g;
          m_data <= req_rot[g] ? d : (req_dir[g] ? d >> n : d << n);
        end
      end else if (m_valid && rsp_ready) begin
        m_valid <= 0;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [N-1:0] er;
    logic [W-1:0] ed;
    logic [2:0]   ea;
    logic         edir;
    int g;
    er = '0; ed = '0; ea = '0; edir = 1'b0;
    if (rst_n) begin
      if (m_busy) begin
        ed = m_pdata; ea = 3'(W - m_pamt); edir = !m_pdir;
      end else begin
        g = pick(m_rr, req_valid);
        if ((!m_valid || rsp_ready) && g >= 0) begin
          er[g] = 1'b1;
          ed = req_data[g*W +: W]; ea = req_amt[g*3 +: 3]; edir = req_dir[g];
        end
      end
    end
    chk("cyc_req_ready", 32'(req_ready), 32'(er));
    chk("cyc_sh_data_in", 32'(sh_data_in), 32'(ed));
    chk("cyc_sh_shift_amt", 32'(sh_shift_amt), 32'(ea));
    chk("cyc_sh_dir", 32'(sh_dir), 32'(edir));
    chk("cyc_busy", 32'(busy), 32'(m_busy));
    chk("cyc_rsp_valid", 32'(rsp_valid), 32'(m_valid));
    chk("cyc_rsp_data", 32'(rsp_data), 32'(m_data));
    chk("cyc_rsp_id", 32'(rsp_id), 32'(m_id));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input int a, input bit dir, input bit rot);
    req_data[i*W +: W] = d;
    req_amt[i*3 +: 3]  = 3'(a);
    req_dir[i]         = dir;
    req_rot[i]         = rot;
    req_valid[i]       = 1'b1;
  endtask

  int fair1[5] = '{0, 1, 2, 3, 0};
  int fair2[4] = '{2, 3, 0, 2};

  initial begin
    rst_n = 0; req_valid = '1; req_data = '0; req_amt = '0; req_dir = '0; req_rot = '0;
    rsp_ready = 1;
    #2;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    cyc(); cyc();
    rst_n = 1; req_valid = '0;

    // Single left shift
    set_req(0, 8'h96, 3, 0, 0);
    #1 chk("shl_ready", 32'(req_ready), 32'h1);
    cyc(); req_valid = '0;
    chk("shl_valid", 32'(rsp_valid), 1);
    chk("shl_data", 32'(rsp_data), 32'hB0);
    chk("shl_id", 32'(rsp_id), 0);

    // Reset mid-rotate
    set_req(1, 8'h33, 2, 0, 1);
    cyc(); req_valid = '0;
    chk("rmr_busy", 32'(busy), 1);
    rst_n = 0;
    #1;
    chk("rmr_busy_clr", 32'(busy), 0);
    chk("rmr_valid_clr", 32'(rsp_valid), 0);
    cyc(); rst_n = 1;

    // Fairness
    for (int i = 0; i < N; i++) set_req(i, 8'(8'h10 + i), 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("fair_id", 32'(rsp_id), 32'(fair1[k]));
      chk("fair_data", 32'(rsp_data), 32'(8'h10 + fair1[k]));
    end
    req_valid[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("fair_drop_id", 32'(rsp_id), 32'(fair2[k]));
    end

    // Backpressure
    rsp_ready = 0;
    #1 chk("bp_ready", 32'(req_ready), 0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("bp_hold_id", 32'(rsp_id), 2);
      chk("bp_hold_data", 32'(rsp_data), 32'h12);
    end
    rsp_ready = 1;
    #1 chk("bp_release_ready", 32'(req_ready), 32'h8);
    cyc(); req_valid = '0;
    chk("bp_new_id", 32'(rsp_id), 3);
    chk("bp_new_data", 32'(rsp_data), 32'h13);
    cyc();
    chk("bp_drained", 32'(rsp_valid), 0);

    // Rotate right
    set_req(2, 8'h81, 1, 1, 1);
    #1 chk("ror_pass1_amt", 32'(sh_shift_amt), 1);
    cyc(); req_valid = '0;
    set_req(0, 8'h01, 1, 0, 0);
    #1;
    chk("ror_busy", 32'(busy), 1);
    chk("ror_pass2_data", 32'(sh_data_in), 32'h81);
    chk("ror_pass2_amt", 32'(sh_shift_amt), 7);
    chk("ror_pass2_dir", 32'(sh_dir), 0);
    chk("ror_no_grant", 32'(req_ready), 0);
    cyc();
    chk("ror_data", 32'(rsp_data), 32'hC0);
    chk("ror_id", 32'(rsp_id), 2);
    cyc(); req_valid = '0;
    chk("after_ror_shift", 32'(rsp_data), 32'h02);

    // Rotate with zero amount
    set_req(1, 8'h5A, 0, 0, 1);
    cyc(); req_valid = '0;
    chk("rot0_busy", 32'(busy), 0);
    chk("rot0_data", 32'(rsp_data), 32'h5A);
    chk("rot0_id", 32'(rsp_id), 1);

    // Rotate left
    set_req(3, 8'hA5, 3, 0, 1);
    cyc(); req_valid = '0;
    cyc();
    chk("rol_data", 32'(rsp_data), 32'h2D);
    chk("rol_id", 32'(rsp_id), 3);
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
